// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU data-memory and stack interface.
// Services RD/WR/psh/pop from a word-addressed RAM after WAIT cycles, ready/err pulse on completion.
module cpu_mem_responder #(
  parameter int              AW        = 10,
  parameter int              DW        = 16,
  parameter int              WAIT      = 2,
  parameter logic [AW-1:0]   SP_TOP    = 10'h3FF,
  parameter logic [AW-1:0]   SP_BOTTOM = 10'h300
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RD,
  input  logic          WR,
  input  logic          psh,
  input  logic          pop,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          err,
  output logic          busy,
  output logic [AW-1:0] sp
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_PSH, OP_POP} op_t;

  localparam logic [3:0]    WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
  localparam logic [AW-1:0] SP_FULL   = SP_BOTTOM - 1'b1;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  state_t        state;
  op_t           op_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          conflict_q;
  logic [3:0]    cnt;

  logic [2:0]    n_strobe;
  logic          any_strobe;
  op_t           op_next;
  logic          illegal;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] sp_inc;

  always_comb begin
    n_strobe   = 3'(RD) + 3'(WR) + 3'(psh) + 3'(pop);
    any_strobe = (n_strobe != 3'd0);
    op_next    = OP_POP;
    if (RD)       op_next = OP_RD;
    else if (WR)  op_next = OP_WR;
    else if (psh) op_next = OP_PSH;
  end

  // Bounds are judged against sp at response time; sp cannot move while a request is in flight.
  always_comb begin
    sp_inc    = sp + 1'b1;
    illegal   = conflict_q
              | ((op_q == OP_PSH) && (sp == SP_FULL))
              | ((op_q == OP_POP) && (sp == SP_TOP));
    mem_we    = (state == ST_RESP) && !illegal && ((op_q == OP_WR) || (op_q == OP_PSH));
    mem_waddr = (op_q == OP_PSH) ? sp : addr_q;
  end

  // Reset in the response cycle aborts the write; RAM contents themselves are never cleared.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_waddr] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ready      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      sp         <= SP_TOP;
      cnt        <= '0;
      op_q       <= OP_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= any_strobe;
          if (any_strobe) begin
            op_q       <= op_next;
            addr_q     <= addr;
            wdata_q    <= wdata;
            conflict_q <= (n_strobe > 3'd1);
            if (WAIT > 0) begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        ST_RESP: begin
          ready <= 1'b1;
          err   <= illegal;
          state <= ST_IDLE;
          if (!illegal) begin
            case (op_q)
              OP_RD:  rdata <= mem[addr_q];
              OP_PSH: sp    <= sp - 1'b1;
              OP_POP: begin
                sp    <= sp_inc;
                rdata <= mem[sp_inc];
              end
              default: ;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed scenarios plus random traffic against a transaction-level model.
module tb_cpu_mem_responder;

  localparam int          WAIT_A    = 2;
  localparam logic [9:0]  SP_TOP    = 10'h3FF;
  localparam logic [9:0]  SP_FULL   = 10'h2FF;
  localparam logic [3:0]  S_RD = 4'b1000, S_WR = 4'b0100, S_PSH = 4'b0010, S_POP = 4'b0001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        rd_a = 0, wr_a = 0, psh_a = 0, pop_a = 0;
  logic [9:0]  addr_a = '0;
  logic [15:0] wdata_a = '0;
  logic [15:0] rdata_a;
  logic        ready_a, err_a, busy_a;
  logic [9:0]  sp_a;

  logic        rd_b = 0, wr_b = 0, psh_b = 0, pop_b = 0;
  logic [9:0]  addr_b = '0;
  logic [15:0] wdata_b = '0;
  logic [15:0] rdata_b;
  logic        ready_b, err_b, busy_b;
  logic [9:0]  sp_b;

  cpu_mem_responder #(.AW(10), .DW(16), .WAIT(WAIT_A), .SP_TOP(10'h3FF), .SP_BOTTOM(10'h300)) dut (
    .clk(clk), .reset(reset), .RD(rd_a), .WR(wr_a), .psh(psh_a), .pop(pop_a),
    .addr(addr_a), .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a),
    .busy(busy_a), .sp(sp_a));

  cpu_mem_responder #(.AW(10), .DW(16), .WAIT(0), .SP_TOP(10'h3FF), .SP_BOTTOM(10'h300)) dut0 (
    .clk(clk), .reset(reset), .RD(rd_b), .WR(wr_b), .psh(psh_b), .pop(pop_b),
    .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b),
    .busy(busy_b), .sp(sp_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Transaction-level reference for the WAIT=2 instance: each accepted request is resolved
  // from the stack/memory rules and its effects appear WAIT+1 edges after acceptance.
  logic [15:0] mm [1024];
  bit          known [1024];
  bit          model_on = 0;
  int          m_remain;
  logic        m_ready, m_err, m_busy, m_rknown;
  logic [15:0] m_rdata;
  logic [9:0]  m_sp;
  logic [3:0]  p_strb;
  logic [9:0]  p_addr;
  logic [15:0] p_wdata;

  always @(posedge clk) begin
    if (reset) begin
      m_remain = 0; m_sp = SP_TOP; m_rdata = '0; m_rknown = 1;
      m_ready = 0; m_err = 0; m_busy = 0; model_on = 1;
    end else if (model_on) begin
      m_ready = 0; m_err = 0;
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          m_ready = 1;
          if ($countones(p_strb) > 1) m_err = 1;
          else if (p_strb[3]) begin m_rdata = mm[p_addr]; m_rknown = known[p_addr]; end
          else if (p_strb[2]) begin mm[p_addr] = p_wdata; known[p_addr] = 1; end
          else if (p_strb[1]) begin
            if (m_sp == SP_FULL) m_err = 1;
            else begin mm[m_sp] = p_wdata; known[m_sp] = 1; m_sp = m_sp - 10'd1; end
          end else begin
            if (m_sp == SP_TOP) m_err = 1;
            else begin m_sp = m_sp + 10'd1; m_rdata = mm[m_sp]; m_rknown = known[m_sp]; end
          end
        end
      end else if ({rd_a, wr_a, psh_a, pop_a} != 4'b0) begin
        p_strb = {rd_a, wr_a, psh_a, pop_a}; p_addr = addr_a; p_wdata = wdata_a;
        m_remain = WAIT_A + 1; m_busy = 1;
      end else begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("cyc_ready", {31'b0, ready_a}, {31'b0, m_ready});
      check("cyc_err",   {31'b0, err_a},   {31'b0, m_err});
      check("cyc_busy",  {31'b0, busy_a},  {31'b0, m_busy});
      check("cyc_sp",    {22'b0, sp_a},    {22'b0, m_sp});
      if (m_rknown) check("cyc_rdata", {16'b0, rdata_a}, {16'b0, m_rdata});
    end
  end

  task automatic drive(input bit sel, input logic [3:0] s, input logic [9:0] a, input logic [15:0] d);
    if (!sel) begin {rd_a, wr_a, psh_a, pop_a} = s; addr_a = a; wdata_a = d; end
    else      begin {rd_b, wr_b, psh_b, pop_b} = s; addr_b = a; wdata_b = d; end
  endtask

  // Called at a falling edge; returns at the falling edge inside the ready cycle.
  task automatic req(input bit sel, input logic [3:0] s, input logic [9:0] a, input logic [15:0] d,
                     output int lat, output logic e, output logic [15:0] rv, output logic [9:0] spv);
    drive(sel, s, a, d);
    @(negedge clk);
    drive(sel, 4'b0, a, d);
    lat = 0;
    while (!(sel ? ready_b : ready_a) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout at %0t: no ready within %0d cycles", $time, lat);
    end
    e   = sel ? err_b : err_a;
    rv  = sel ? rdata_b : rdata_a;
    spv = sel ? sp_b : sp_a;
  endtask

  int          lat, cnt_r;
  logic        e;
  logic [15:0] rv;
  logic [9:0]  s;
  logic [3:0]  strb;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_sp",    {22'b0, sp_a},    32'h3FF);
    check("rst_ready", {31'b0, ready_a}, 32'h0);
    check("rst_err",   {31'b0, err_a},   32'h0);
    check("rst_busy",  {31'b0, busy_a},  32'h0);
    check("rst_rdata", {16'b0, rdata_a}, 32'h0);
    check("rst_sp0",   {22'b0, sp_b},    32'h3FF);
    reset = 0;
    @(negedge clk);

    req(0, S_WR, 10'h2FF, 16'h7777, lat, e, rv, s);
    req(0, S_WR, 10'h020, 16'h1234, lat, e, rv, s);
    req(0, S_WR, 10'h030, 16'h5555, lat, e, rv, s);

    req(0, S_WR, 10'h010, 16'hBEEF, lat, e, rv, s);
    check("wr_lat", lat, 3);
    check("wr_err", {31'b0, e}, 0);
    req(0, S_RD, 10'h010, 16'h0000, lat, e, rv, s);
    check("rd_lat", lat, 3);
    check("rd_data", {16'b0, rv}, 32'hBEEF);
    check("rd_err", {31'b0, e}, 0);

    req(1, S_WR, 10'h010, 16'hBEEF, lat, e, rv, s);
    check("w0_wr_lat", lat, 1);
    req(1, S_RD, 10'h010, 16'h0000, lat, e, rv, s);
    check("w0_rd_lat", lat, 1);
    check("w0_rd_data", {16'b0, rv}, 32'hBEEF);

    req(0, S_PSH, 10'h0, 16'h1111, lat, e, rv, s);
    check("psh1_sp", {22'b0, s}, 32'h3FE);
    req(0, S_PSH, 10'h0, 16'h2222, lat, e, rv, s);
    check("psh2_sp", {22'b0, s}, 32'h3FD);
    req(0, S_POP, 10'h0, 16'h0, lat, e, rv, s);
    check("pop1_data", {16'b0, rv}, 32'h2222);
    check("pop1_sp", {22'b0, s}, 32'h3FE);
    req(0, S_POP, 10'h0, 16'h0, lat, e, rv, s);
    check("pop2_data", {16'b0, rv}, 32'h1111);
    check("pop2_sp", {22'b0, s}, 32'h3FF);

    req(0, S_POP, 10'h0, 16'h0, lat, e, rv, s);
    check("unf_err", {31'b0, e}, 1);
    check("unf_sp", {22'b0, s}, 32'h3FF);
    check("unf_rdata", {16'b0, rv}, 32'h1111);

    for (int i = 0; i < 256; i++) req(0, S_PSH, 10'h0, 16'h4000 + 16'(i), lat, e, rv, s);
    check("full_sp", {22'b0, s}, 32'h2FF);
    req(0, S_PSH, 10'h0, 16'hFFFF, lat, e, rv, s);
    check("ovf_err", {31'b0, e}, 1);
    check("ovf_sp", {22'b0, s}, 32'h2FF);
    req(0, S_RD, 10'h2FF, 16'h0, lat, e, rv, s);
    check("ovf_mem", {16'b0, rv}, 32'h7777);
    for (int i = 0; i < 256; i++) req(0, S_POP, 10'h0, 16'h0, lat, e, rv, s);
    check("drain_sp", {22'b0, s}, 32'h3FF);
    check("drain_last", {16'b0, rv}, 32'h4000);

    req(0, S_RD | S_WR, 10'h020, 16'hDEAD, lat, e, rv, s);
    check("cfl_err", {31'b0, e}, 1);
    check("cfl_rdata", {16'b0, rv}, 32'h4000);
    req(0, S_RD, 10'h020, 16'h0, lat, e, rv, s);
    check("cfl_mem", {16'b0, rv}, 32'h1234);

    drive(0, S_RD, 10'h010, 16'h0);
    @(negedge clk);
    drive(0, 4'b0, 10'h010, 16'h0);
    cnt_r = 0;
    @(negedge clk);
    drive(0, S_WR, 10'h010, 16'h0BAD);
    @(negedge clk);
    @(negedge clk);
    drive(0, 4'b0, 10'h010, 16'h0);
    if (ready_a) cnt_r++;
    repeat (5) begin @(negedge clk); if (ready_a) cnt_r++; end
    check("busy_ignore", cnt_r, 1);
    req(0, S_RD, 10'h010, 16'h0, lat, e, rv, s);
    check("busy_mem", {16'b0, rv}, 32'hBEEF);

    drive(0, S_WR, 10'h030, 16'hAAAA);
    @(negedge clk);
    drive(0, 4'b0, 10'h030, 16'h0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    cnt_r = 0;
    repeat (6) begin @(negedge clk); if (ready_a) cnt_r++; end
    check("abort_ready", cnt_r, 0);
    req(0, S_RD, 10'h030, 16'h0, lat, e, rv, s);
    check("abort_mem", {16'b0, rv}, 32'h5555);

    for (int i = 0; i < 300; i++) begin
      int k;
      k = $urandom_range(0, 15);
      if (k < 4)       strb = S_RD;
      else if (k < 8)  strb = S_WR;
      else if (k < 11) strb = S_PSH;
      else if (k < 14) strb = S_POP;
      else             strb = S_RD | 4'(1 << $urandom_range(0, 2));
      req(0, strb, 10'($urandom_range(0, 15)), 16'($urandom), lat, e, rv, s);
      check("rand_lat", lat, 3);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t: simulation did not complete", $time);
    $fatal(1);
  end

endmodule
